spi_slave: RTL and testbench

SPI responder that pairs with the team's SPI master: full-duplex, LSB-first, 8-bit frames, multi-byte transfers while ss_n stays low. All SPI pins are oversampled in the clk domain; the block needs no SPI-clock domain. On the fabric side it presents each received byte as a valid pulse and requests each transmit byte with a read pulse. It sits between an external SPI bus and a register file or FIFO.

---
 rtl/spi_slave_if.sv | 24 ++
 rtl/spi_slave.sv | 132 +++++++++++++
 tb/tb_spi_slave.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI pin group plus the byte-wide fabric handshake of the SPI responder.
// The slave modport is the responder's view; master is the bus/fabric driver's view.
interface spi_slave_if;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_tri;
  logic       read;
  logic [7:0] tx_data;
  logic       valid;
  logic [7:0] rx_data;
  logic       busy;

  modport slave (
    input  sclk, ss_n, mosi, tx_data,
    output miso, miso_tri, read, valid, rx_data, busy
  );

  modport master (
    output sclk, ss_n, mosi, tx_data,
    input  miso, miso_tri, read, valid, rx_data, busy
  );
endinterface

// File: rtl/spi_slave.sv
// Oversampled full-duplex LSB-first SPI responder, 8-bit frames, all logic in the clk domain.
// Pin-to-event 2-3 clk; valid/read pulse one clk after the 8th sample; no backpressure, consumer must keep up.
module spi_slave #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CAP, XFER} state_t;

  state_t     state_q, state_d;
  logic [2:0] sclk_q, ss_q, mosi_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic       read_q, read_d;
  logic       cap_q, cap_d;

  logic sclk_edge, lead_ev, trail_ev, sample_ev, shift_ev;
  logic ss_fall, ss_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= {3{CPOL}};
      ss_q   <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.sclk};
      ss_q   <= {ss_q[1:0], bus.ss_n};
      mosi_q <= {mosi_q[1:0], bus.mosi};
    end
  end

  assign sclk_edge = sclk_q[1] ^ sclk_q[2];
  assign lead_ev   = sclk_edge && (sclk_q[1] != CPOL);
  assign trail_ev  = sclk_edge && (sclk_q[1] == CPOL);
  assign sample_ev = CPHA ? trail_ev : lead_ev;
  assign shift_ev  = CPHA ? lead_ev : trail_ev;
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      read_q     <= 1'b0;
      cap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      read_q     <= read_d;
      cap_q      <= cap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = cap_q ? bus.tx_data : tx_buf_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    valid_d    = done_q;
    read_d     = done_q;
    cap_d      = read_q;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = LOAD;
          read_d  = 1'b1;
        end
      end
      LOAD: state_d = CAP;
      CAP: begin
        state_d = XFER;
        if (!CPHA) tx_shift_d = bus.tx_data;
      end
      XFER: begin
        // mosi stage 3 is one clk older than the detected edge, well inside the master's setup window
        if (sample_ev) begin
          rx_shift_d = {mosi_q[2], rx_shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d = rx_shift_d;
            done_d    = 1'b1;
          end
        end
        // bit_cnt==0 on a shift edge marks a byte boundary in both phases
        if (shift_ev) begin
          tx_shift_d = (bit_cnt_q == 3'd0) ? tx_buf_q : {1'b0, tx_shift_q[7:1]};
        end
      end
      default: state_d = IDLE;
    endcase

    if (ss_rise) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      done_d     = 1'b0;
    end
  end

  assign bus.miso     = tx_shift_q[0];
  assign bus.miso_tri = ss_q[1];
  assign bus.busy     = ~ss_q[1];
  assign bus.read     = read_q;
  assign bus.valid    = valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// Drives all four CPOL/CPHA variants of spi_slave from a bit-level SPI master
// and scores bytes both ways against the frame-level expectations.
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] sclk_v, ss_v, mosi_v;
  logic [3:0] miso_v, tri_v, read_v, valid_v, busy_v;
  logic [7:0] tx_v [4] = '{default: 8'h00};
  logic [7:0] rx_v [4];

  int rd_cnt [4] = '{default: 0};
  int vl_cnt [4] = '{default: 0};
  int rdb [4];
  int vlb [4];
  int cur = -1;
  int unstab;
  int checks = 0;
  int errors = 0;
  int bad;
  logic mid_busy, mid_tri, rb;
  logic [7:0] tx_src[$], handed[$], rx_got[$], send_q[$], mrx[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_if bus ();
    spi_slave #(.CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.sclk    = sclk_v[g];
    assign bus.ss_n    = ss_v[g];
    assign bus.mosi    = mosi_v[g];
    assign bus.tx_data = tx_v[g];
    assign miso_v[g]   = bus.miso;
    assign tri_v[g]    = bus.miso_tri;
    assign read_v[g]   = bus.read;
    assign valid_v[g]  = bus.valid;
    assign busy_v[g]   = bus.busy;
    assign rx_v[g]     = bus.rx_data;
  end

  // Fabric-side responder: hands out the next queued tx byte on every read pulse.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (read_v[g] === 1'b1) begin
        rd_cnt[g]++;
        if (g == cur) begin
          tx_v[g] = (tx_src.size() > 0) ? tx_src.pop_front() : 8'h00;
          handed.push_back(tx_v[g]);
        end
      end
      if (valid_v[g] === 1'b1) begin
        vl_cnt[g]++;
        if (g == cur) rx_got.push_back(rx_v[g]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_bit(input int m, input logic b, input int hp, output logic bit_in);
    logic cpol, pre;
    cpol = (m >= 2);
    if (m % 2 == 1) sclk_v[m] = ~cpol;
    mosi_v[m] = b;
    repeat (hp - 1) @(negedge clk);
    pre = miso_v[m];
    @(negedge clk);
    bit_in = miso_v[m];
    if (bit_in !== pre) unstab++;
    if (m % 2 == 0) begin
      sclk_v[m] = ~cpol;
      repeat (hp) @(negedge clk);
      sclk_v[m] = cpol;
    end else begin
      sclk_v[m] = cpol;
      repeat (hp) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int m, input int nbits, input int hp);
    logic [7:0] acc, sb;
    acc = 8'h00;
    mrx.delete();
    ss_v[m] = 1'b0;
    repeat (6) @(negedge clk);
    mid_busy = busy_v[m];
    mid_tri  = tri_v[m];
    for (int i = 0; i < nbits; i++) begin
      sb = send_q[i / 8];
      do_bit(m, sb[i % 8], hp, rb);
      acc[i % 8] = rb;
      if (i % 8 == 7) mrx.push_back(acc);
    end
    repeat (hp) @(negedge clk);
    ss_v[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Expected outcome of a frame: every complete byte arrives once in order, the master
  // receives the bytes handed out on reads in order, one read at select plus one per byte.
  task automatic frame_test(input string tag, input int m, input int nbits, input int hp);
    int full, rd0, vl0;
    logic [7:0] prior, exp_rx, got;
    cur = m;
    rx_got.delete();
    handed.delete();
    unstab = 0;
    rd0 = rd_cnt[m];
    vl0 = vl_cnt[m];
    prior = rx_v[m];
    run_frame(m, nbits, hp);
    full = nbits / 8;
    chk($sformatf("%s_m%0d_valid_cnt", tag, m), vl_cnt[m] - vl0, full);
    chk($sformatf("%s_m%0d_read_cnt", tag, m), rd_cnt[m] - rd0, full + 1);
    for (int k = 0; k < full; k++) begin
      got = (k < rx_got.size()) ? rx_got[k] : 8'hxx;
      chk($sformatf("%s_m%0d_rx_byte%0d", tag, m, k), got, send_q[k]);
      got = (k < handed.size()) ? handed[k] : 8'hxx;
      chk($sformatf("%s_m%0d_miso_byte%0d", tag, m, k), mrx[k], got);
    end
    exp_rx = (full > 0) ? send_q[full - 1] : prior;
    chk($sformatf("%s_m%0d_rx_data", tag, m), rx_v[m], exp_rx);
    chk($sformatf("%s_m%0d_busy_mid", tag, m), mid_busy, 1'b1);
    chk($sformatf("%s_m%0d_tri_mid", tag, m), mid_tri, 1'b0);
    chk($sformatf("%s_m%0d_busy_end", tag, m), busy_v[m], 1'b0);
    chk($sformatf("%s_m%0d_tri_end", tag, m), tri_v[m], 1'b1);
    chk($sformatf("%s_m%0d_miso_stable", tag, m), unstab, 0);
  endtask

  initial begin
    sclk_v = 4'b1100;
    ss_v   = 4'b1111;
    mosi_v = 4'b0000;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_m%0d_rx_data", m), rx_v[m], 8'h00);
      chk($sformatf("rst_m%0d_valid", m), valid_v[m], 1'b0);
      chk($sformatf("rst_m%0d_read", m), read_v[m], 1'b0);
      chk($sformatf("rst_m%0d_busy", m), busy_v[m], 1'b0);
      chk($sformatf("rst_m%0d_tri", m), tri_v[m], 1'b1);
      chk($sformatf("rst_m%0d_miso", m), miso_v[m], 1'b0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_q = {8'hA5};
    tx_src = {8'h3C, 8'h3C};
    frame_test("single", 0, 8, 5);
    chk("single_master_rx", mrx[0], 8'h3C);

    send_q = {8'h01, 8'h80, 8'hFF};
    tx_src = {8'h11, 8'h22, 8'h33, 8'h00};
    frame_test("multi", 0, 24, 5);
    chk("multi_master_rx2", mrx[2], 8'h33);

    for (int m = 0; m < 4; m++) begin
      send_q = {8'h5A};
      tx_src = {8'h5A, 8'h5A};
      frame_test("mode", m, 8, 5);
    end

    send_q = {8'hC3};
    tx_src = {8'h44};
    frame_test("abort", 0, 5, 5);
    send_q = {8'h96};
    tx_src = {8'h69, 8'h00};
    frame_test("post_abort", 0, 8, 6);

    cur = 0;
    ss_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) do_bit(0, i[0], 5, rb);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rx_data", rx_v[0], 8'h00);
    chk("midrst_valid", valid_v[0], 1'b0);
    chk("midrst_read", read_v[0], 1'b0);
    chk("midrst_busy", busy_v[0], 1'b0);
    chk("midrst_tri", tri_v[0], 1'b1);
    chk("midrst_miso", miso_v[0], 1'b0);
    ss_v[0] = 1'b1;
    repeat (12) @(negedge clk);
    send_q = {8'h7E};
    tx_src = {8'hE7, 8'h00};
    frame_test("post_rst", 0, 8, 5);

    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < 2; r++) begin
        send_q = {8'($urandom), 8'($urandom)};
        tx_src = {8'($urandom), 8'($urandom), 8'($urandom)};
        frame_test("rand", m, 16, int'($urandom_range(5, 8)));
      end
    end

    cur = -1;
    bad = 0;
    for (int m = 0; m < 4; m++) begin
      rdb[m] = rd_cnt[m];
      vlb[m] = vl_cnt[m];
    end
    for (int t = 0; t < 12; t++) begin
      sclk_v = ~sclk_v;
      mosi_v = 4'($urandom);
      repeat (5) @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        if (busy_v[m] !== 1'b0 || tri_v[m] !== 1'b1) bad++;
      end
    end
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("idle_m%0d_read_cnt", m), rd_cnt[m] - rdb[m], 0);
      chk($sformatf("idle_m%0d_valid_cnt", m), vl_cnt[m] - vlb[m], 0);
    end
    chk("idle_busy_tri", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
